// File: rtl/alu_core_pkg.sv
// rtl/alu_core_pkg.sv - opcode, error-code and state definitions shared by alu_core.
package alu_core_pkg;

  typedef enum logic [7:0] {
    OP_NOP = 8'd0,
    OP_ADD = 8'd1,
    OP_AND = 8'd2,
    OP_XOR = 8'd3,
    OP_MUL = 8'd4,
    OP_DIV = 8'd5,
    OP_LDA = 8'd6,
    OP_STA = 8'd7,
    OP_MOV = 8'd8,
    OP_SWP = 8'd9,
    OP_WMR = 8'd10
  } operation_t;

  localparam logic [7:0] ERR_OK       = 8'd0;
  localparam logic [7:0] ERR_ILLEGAL  = 8'd1;
  localparam logic [7:0] ERR_DIV_ZERO = 8'd2;
  localparam logic [7:0] ERR_ADDR     = 8'd3;
  localparam logic [7:0] ERR_DIV_OVF  = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic calc_gp(input logic sv, input logic [63:0] r);
    return sv ? ($signed(r) > 64'sd0) : (r != 64'd0);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - 32-iteration restoring divider on magnitudes with sign fixup.
module alu_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sv,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [4:0]  iter_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic [32:0] rem_shift;
  logic [32:0] trial;

  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      iter_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo_q   <= (sv && dividend[31]) ? -dividend : dividend;
        dvs_q   <= (sv && divisor[31]) ? -divisor : divisor;
        rem_q   <= '0;
        iter_q  <= '0;
        busy    <= 1'b1;
        q_neg_q <= sv & (dividend[31] ^ divisor[31]);
        r_neg_q <= sv & dividend[31];
      end else if (busy) begin
        // trial[32] set means the shifted remainder was smaller than the divisor
        if (trial[32]) begin
          rem_q <= rem_shift[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end else begin
          rem_q <= trial[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end
        iter_q <= iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = q_neg_q ? -quo_q : quo_q;
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - multi-cycle 32-bit ALU with start/done handshake and accumulator.
// Defining ALU_MEM_OPS_EN adds the scratch memory behind lda/sta/wmr.
module alu_core
  import alu_core_pkg::*;
#(
  parameter int MEM_DEPTH = 16,
  parameter int MUL_LAT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sv,
  input  logic        op_prefix,
  input  logic [7:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        done,
  output logic        gp,
  output logic [63:0] result,
  output logic [7:0]  err
);

  state_t      state_q;
  logic        sv_q;
  logic [7:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc_q;
  logic [7:0]  cnt_q;
  logic        div_run_q;
  logic        div_ovf_q;

  logic [31:0] a_in;
  logic        div_ovf_in;
  logic        div_ok_in;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        exec_fin;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] res_n;
  logic [7:0]  err_n;
  logic        acc_ld;

  assign a_in       = op_prefix ? acc_q[31:0] : A;
  assign div_ovf_in = sv && (a_in == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign div_ok_in  = (op == OP_DIV) && (B != 32'd0) && !div_ovf_in;
  // Divider launches on the capture edge so its 32 iterations fit the 33-clock budget
  assign div_start  = (state_q == ST_IDLE) && start && div_ok_in;

  alu_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .sv        (sv),
    .dividend  (a_in),
    .divisor   (B),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign exec_fin = div_run_q ? (div_done && !div_busy) : (cnt_q == 8'd0);
  assign ext_a    = {{32{sv_q & a_q[31]}}, a_q};
  assign ext_b    = {{32{sv_q & b_q[31]}}, b_q};

`ifdef ALU_MEM_OPS_EN
  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] mem [MEM_DEPTH];
  logic        addr_ok;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  assign addr_ok   = a_q < 32'(MEM_DEPTH);
  assign mem_rdata = mem[a_q[AW-1:0]];

  // No reset on the array; writes only land on the completing edge
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_EXEC) && exec_fin && mem_we) begin
      mem[a_q[AW-1:0]] <= mem_wdata;
    end
  end
`endif

  always_comb begin
    res_n  = '0;
    err_n  = ERR_OK;
    acc_ld = 1'b0;
`ifdef ALU_MEM_OPS_EN
    mem_we    = 1'b0;
    mem_wdata = b_q;
`endif
    case (op_q)
      OP_NOP: res_n = '0;
      OP_ADD: begin
        res_n  = ext_a + ext_b;
        acc_ld = 1'b1;
      end
      OP_AND: begin
        res_n  = {32'd0, a_q & b_q};
        acc_ld = 1'b1;
      end
      OP_XOR: begin
        res_n  = {32'd0, a_q ^ b_q};
        acc_ld = 1'b1;
      end
      OP_MUL: begin
        res_n  = ext_a * ext_b;
        acc_ld = 1'b1;
      end
      OP_DIV: begin
        if (b_q == 32'd0) begin
          err_n = ERR_DIV_ZERO;
        end else if (div_ovf_q) begin
          err_n = ERR_DIV_OVF;
          res_n = {32'd0, 32'h8000_0000};
        end else begin
          res_n  = {div_rem, div_quo};
          acc_ld = 1'b1;
        end
      end
      OP_MOV: begin
        res_n  = {32'd0, b_q};
        acc_ld = 1'b1;
      end
      OP_SWP: begin
        res_n  = {b_q, a_q};
        acc_ld = 1'b1;
      end
`ifdef ALU_MEM_OPS_EN
      OP_LDA: begin
        if (addr_ok) begin
          res_n  = {32'd0, mem_rdata};
          acc_ld = 1'b1;
        end else begin
          err_n = ERR_ADDR;
        end
      end
      OP_STA: begin
        if (addr_ok) begin
          mem_we = 1'b1;
          res_n  = {32'd0, b_q};
        end else begin
          err_n = ERR_ADDR;
        end
      end
      OP_WMR: begin
        if (addr_ok) begin
          mem_we    = 1'b1;
          mem_wdata = acc_q[31:0];
          res_n     = acc_q;
          acc_ld    = 1'b1;
        end else begin
          err_n = ERR_ADDR;
        end
      end
`endif
      default: err_n = ERR_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      done      <= 1'b0;
      gp        <= 1'b0;
      result    <= '0;
      err       <= ERR_OK;
      acc_q     <= '0;
      sv_q      <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      div_run_q <= 1'b0;
      div_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sv_q      <= sv;
            op_q      <= op;
            a_q       <= a_in;
            b_q       <= B;
            div_run_q <= div_ok_in;
            div_ovf_q <= div_ovf_in;
            cnt_q     <= (op == OP_MUL) ? 8'(MUL_LAT - 1) : 8'd0;
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_fin) begin
            result  <= res_n;
            err     <= err_n;
            gp      <= calc_gp(sv_q, res_n);
            if (acc_ld && (err_n == ERR_OK)) begin
              acc_q <= res_n;
            end
            done    <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_DONE: begin
          if (!start) begin
            done    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed scoreboard bench for alu_core (honours ALU_MEM_OPS_EN).
module tb_alu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sv;
  logic        op_prefix;
  logic [7:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        done;
  logic        gp;
  logic [63:0] result;
  logic [7:0]  err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    logic [7:0]  err;
    logic        gp;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  alu_core #(.MEM_DEPTH(16), .MUL_LAT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sv        (sv),
    .op_prefix (op_prefix),
    .op        (op),
    .A         (A),
    .B         (B),
    .done      (done),
    .gp        (gp),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic issue(input logic [7:0] o, input logic s, input logic p,
                       input logic [31:0] a, input logic [31:0] b);
    op = o; sv = s; op_prefix = p; A = a; B = b;
    start = 1'b1;
  endtask

  task automatic push_exp(input logic [63:0] r, input logic [7:0] e, input logic g, input int lat);
    exp_t x;
    x.res = r; x.err = e; x.gp = g; x.lat = lat;
    sbq.push_back(x);
  endtask

  task automatic compare_pop(input string tag, input int lat);
    exp_t x;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb got=empty exp=entry", tag);
    end else begin
      x = sbq.pop_front();
      check({tag, ".lat"}, 64'(lat), 64'(x.lat));
      check({tag, ".res"}, result, x.res);
      check({tag, ".err"}, 64'(err), 64'(x.err));
      check({tag, ".gp"}, 64'(gp), 64'(x.gp));
    end
  endtask

  // Drives one command, measures capture-to-done latency, then releases start.
  task automatic run(input string tag, input logic [7:0] o, input logic s, input logic p,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] r, input logic [7:0] e, input logic g, input int lat);
    int n;
    n = 0;
    push_exp(r, e, g, lat);
    issue(o, s, p, a, b);
    @(posedge clk);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
    compare_pop(tag, n);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int lat;
    int hi;
    reset = 1'b1; start = 1'b0; sv = 1'b0; op_prefix = 1'b0;
    op = 8'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.done", 64'(done), 64'd0);
    check("rst.result", result, 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.gp", 64'(gp), 64'd0);

    // Reset asserted for two clocks in the middle of a divide
    issue(8'd5, 1'b0, 1'b0, 32'd100, 32'd7);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("abort.done", 64'(done), 64'd0);
    check("abort.result", result, 64'd0);
    check("abort.err", 64'(err), 64'd0);
    run("add34", 8'd1, 1'b0, 1'b0, 32'd3, 32'd4, 64'd7, 8'd0, 1'b1, 1);

    run("add_s", 8'd1, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd0, 1'b0, 1);
    run("mul_u", 8'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 8'd0, 1'b1, 3);
    run("mul_s", 8'd4, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 8'd0, 1'b0, 3);
    run("div_s", 8'd5, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd0, 1'b0, 33);
    run("div_u", 8'd5, 1'b0, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 8'd0, 1'b1, 33);
    run("div_z", 8'd5, 1'b0, 1'b0, 32'd9, 32'd0, 64'd0, 8'd2, 1'b0, 1);
    run("div_ovf", 8'd5, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 8'd4, 1'b1, 1);
    run("and", 8'd2, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 64'h0000_0000_00F0_1234, 8'd0, 1'b1, 1);
    run("mov", 8'd8, 1'b0, 1'b0, 32'd0, 32'h0000_ABCD, 64'h0000_0000_0000_ABCD, 8'd0, 1'b1, 1);
    run("swp", 8'd9, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 64'h2222_2222_1111_1111, 8'd0, 1'b1, 1);
    run("nop", 8'd0, 1'b0, 1'b0, 32'd5, 32'd6, 64'd0, 8'd0, 1'b0, 1);

`ifdef ALU_MEM_OPS_EN
    run("sta3", 8'd7, 1'b0, 1'b0, 32'd3, 32'h55, 64'h55, 8'd0, 1'b1, 1);
    run("lda3", 8'd6, 1'b0, 1'b0, 32'd3, 32'd0, 64'h55, 8'd0, 1'b1, 1);
    run("lda20", 8'd6, 1'b0, 1'b0, 32'd20, 32'd0, 64'd0, 8'd3, 1'b0, 1);
    run("sta16", 8'd7, 1'b0, 1'b0, 32'd16, 32'h77, 64'd0, 8'd3, 1'b0, 1);
`else
    run("sta3", 8'd7, 1'b0, 1'b0, 32'd3, 32'h55, 64'd0, 8'd1, 1'b0, 1);
    run("lda3", 8'd6, 1'b0, 1'b0, 32'd3, 32'd0, 64'd0, 8'd1, 1'b0, 1);
    run("wmr", 8'd10, 1'b0, 1'b0, 32'd3, 32'd0, 64'd0, 8'd1, 1'b0, 1);
`endif

    // Accumulator chaining through op_prefix; illegal op must leave it alone
    run("add11", 8'd1, 1'b0, 1'b0, 32'd1, 32'd1, 64'd2, 8'd0, 1'b1, 1);
    run("xor_pfx", 8'd3, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd3, 64'd1, 8'd0, 1'b1, 1);
    run("illegal", 8'd12, 1'b0, 1'b0, 32'd7, 32'd7, 64'd0, 8'd1, 1'b0, 1);
    run("acc_keep", 8'd1, 1'b0, 1'b1, 32'd0, 32'd0, 64'd1, 8'd0, 1'b1, 1);

    // start dropped during EXEC: done must pulse for exactly one cycle
    push_exp(64'd42, 8'd0, 1'b1, 3);
    issue(8'd4, 1'b0, 1'b0, 32'd6, 32'd7);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; hi = 0; n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        hi++;
        if (lat == 0) lat = n;
      end
    end
    compare_pop("mul_drop", lat);
    check("mul_drop.hi_cycles", 64'(hi), 64'd1);
    check("mul_drop.hold", result, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
